// File: rtl/mmio_bridge.sv
// Byte-bus bridge between the CPU core, block RAM and the I/O page.
// Owns the UART TX FIFO, the RX pop path, the cycle counter and the stop flag.
module mmio_bridge #(
    parameter int TX_DEPTH    = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_we,
    output logic [7:0]  ram_wdata,
    input  logic [7:0]  ram_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        program_stop,
    output logic        tx_overflow
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [17:0] A_UART  = 18'h30000;
    localparam logic [17:0] A_STOP  = 18'h30004;
    localparam logic [17:0] A_SNAP1 = 18'h30005;
    localparam logic [17:0] A_SNAP2 = 18'h30006;
    localparam logic [17:0] A_SNAP3 = 18'h30007;

    logic [7:0]    fifo_mem [TX_DEPTH];

    logic [PW-1:0] wrptr_q, wrptr_d;
    logic [PW-1:0] rdptr_q, rdptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          stop_q, stop_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   counter_q, counter_d;
    logic [31:0]   snap_q, snap_d;
    logic [7:0]    io_q, io_d;
    logic          sel_ram_q, sel_ram_d;
    logic          acc_q, acc_d;
    logic [7:0]    hold_q, hold_d;

    logic [17:0]   addr;
    logic          io, wr_io, rd_io;
    logic          push_req, push, pop, fifo_full;
    logic [7:0]    push_data;
    logic [CW-1:0] free_d;

    logic unused_addr_hi;
    assign unused_addr_hi = ^cpu_a[31:18];

    always_comb begin
        addr      = cpu_a[17:0];
        io        = (cpu_a[17:16] == 2'b11);
        wr_io     = rdy_in & cpu_wr & io;
        rd_io     = rdy_in & ~cpu_wr & io;

        ram_a     = cpu_a[16:0];
        ram_wdata = cpu_dout;
        ram_we    = rdy_in & cpu_wr & ~io;

        push_req  = wr_io & (((addr == A_UART) && (cpu_dout != 8'h00)) || (addr == A_STOP));
        push_data = (addr == A_STOP) ? 8'h00 : cpu_dout;
        fifo_full = (count_q == CW'(TX_DEPTH));
        push      = push_req & ~fifo_full;
        tx_valid  = (count_q != '0);
        tx_data   = fifo_mem[rdptr_q];
        pop       = tx_valid & tx_ready;

        wrptr_d   = push ? wrptr_q + PW'(1) : wrptr_q;
        rdptr_d   = pop ? rdptr_q + PW'(1) : rdptr_q;
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        free_d    = CW'(TX_DEPTH) - count_d;
        full_d    = (free_d <= CW'(FULL_MARGIN));

        ovf_d     = ovf_q | (push_req & fifo_full);
        stop_d    = stop_q | (wr_io & (addr == A_STOP));
        counter_d = rdy_in ? counter_q + 32'd1 : counter_q;

        // I/O read mux; the byte-0 counter read also freezes the snapshot
        rx_pop    = rd_io & (addr == A_UART) & rx_valid;
        snap_d    = snap_q;
        io_d      = 8'h00;
        if (rd_io) begin
            case (addr)
                A_UART:  io_d = rx_valid ? rx_data : 8'h00;
                A_STOP: begin
                    io_d   = counter_q[7:0];
                    snap_d = counter_q;
                end
                A_SNAP1: io_d = snap_q[15:8];
                A_SNAP2: io_d = snap_q[23:16];
                A_SNAP3: io_d = snap_q[31:24];
                default: io_d = 8'h00;
            endcase
        end

        sel_ram_d = rdy_in ? ~io : sel_ram_q;
        io_d      = rdy_in ? io_d : io_q;
        acc_d     = rdy_in;

        // Live mux only after an accepted access; otherwise replay the last byte
        cpu_din   = acc_q ? (sel_ram_q ? ram_rdata : io_q) : hold_q;
        hold_d    = cpu_din;

        io_buffer_full = full_q;
        program_stop   = stop_q;
        tx_overflow    = ovf_q;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wrptr_q   <= '0;
            rdptr_q   <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            stop_q    <= 1'b0;
            ovf_q     <= 1'b0;
            counter_q <= '0;
            snap_q    <= '0;
            io_q      <= '0;
            sel_ram_q <= 1'b0;
            acc_q     <= 1'b0;
            hold_q    <= '0;
        end else begin
            wrptr_q   <= wrptr_d;
            rdptr_q   <= rdptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            stop_q    <= stop_d;
            ovf_q     <= ovf_d;
            counter_q <= counter_d;
            snap_q    <= snap_d;
            io_q      <= io_d;
            sel_ram_q <= sel_ram_d;
            acc_q     <= acc_d;
            hold_q    <= hold_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem[wrptr_q] <= push_data;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with a 1-cycle synchronous RAM model.
module tb_mmio_bridge;
    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] cpu_a;
    logic        cpu_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_stop;
    logic        tx_overflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] ram [0:131071];

    mmio_bridge #(.TX_DEPTH(16), .FULL_MARGIN(2)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .cpu_a(cpu_a), .cpu_wr(cpu_wr), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
        .io_buffer_full(io_buffer_full),
        .ram_a(ram_a), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
        .program_stop(program_stop), .tx_overflow(tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) begin
        if (ram_we) ram[ram_a] <= ram_wdata;
        ram_rdata <= ram[ram_a];
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; cpu_a = 32'h0; cpu_wr = 1'b0; cpu_dout = 8'h00;
        tx_ready = 1'b0; rx_data = 8'h00; rx_valid = 1'b0;
        repeat (3) tick;
        check("rst_cpu_din", 32'(cpu_din), 32'h0);
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_buf_full", 32'(io_buffer_full), 32'h0);
        check("rst_stop", 32'(program_stop), 32'h0);
        check("rst_ovf", 32'(tx_overflow), 32'h0);
        check("rst_count", 32'(dut.count_q), 32'h0);

        // Cycle counter: 499 counted cycles, then snapshot reads
        rst_in = 1'b0; rdy_in = 1'b1;
        repeat (499) tick;
        check("counter_pre", dut.counter_q, 32'h1F3);
        cpu_a = 32'h30004; tick;
        check("snap_b0", 32'(cpu_din), 32'hF3);
        cpu_a = 32'h30005; tick;
        check("snap_b1", 32'(cpu_din), 32'h01);
        cpu_a = 32'h30006; tick;
        check("snap_b2", 32'(cpu_din), 32'h00);
        cpu_a = 32'h30007; tick;
        check("snap_b3", 32'(cpu_din), 32'h00);

        // RAM write then read
        cpu_a = 32'h00010; cpu_wr = 1'b1; cpu_dout = 8'hA5; #1;
        check("ram_we_wr", 32'(ram_we), 32'h1);
        tick;
        cpu_wr = 1'b0; #1;
        check("ram_we_rd", 32'(ram_we), 32'h0);
        tick;
        check("ram_rd", 32'(cpu_din), 32'hA5);

        // RX path
        cpu_a = 32'h30000; rx_valid = 1'b1; rx_data = 8'h37; #1;
        check("rx_pop_hi", 32'(rx_pop), 32'h1);
        tick;
        check("rx_data", 32'(cpu_din), 32'h37);
        rx_valid = 1'b0; #1;
        check("rx_pop_lo", 32'(rx_pop), 32'h0);
        tick;
        check("rx_empty", 32'(cpu_din), 32'h00);

        // TX: 'H', 0x00 (ignored), 'i'
        cpu_wr = 1'b1; cpu_a = 32'h30000;
        cpu_dout = 8'h48; tick;
        cpu_dout = 8'h00; tick;
        cpu_dout = 8'h69; tick;
        cpu_wr = 1'b0; cpu_a = 32'h0;
        check("tx_count2", 32'(dut.count_q), 32'h2);
        check("tx_head_H", 32'(tx_data), 32'h48);
        check("tx_valid1", 32'(tx_valid), 32'h1);
        tx_ready = 1'b1; tick;
        check("tx_head_i", 32'(tx_data), 32'h69);
        tick;
        check("tx_drained", 32'(tx_valid), 32'h0);
        check("tx_ovf0", 32'(tx_overflow), 32'h0);

        // Fill to full and overflow
        tx_ready = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h30000;
        for (int i = 1; i <= 17; i++) begin
            cpu_dout = 8'(i);
            tick;
            if (i == 13) check("full_at13", 32'(io_buffer_full), 32'h0);
            if (i == 14) check("full_at14", 32'(io_buffer_full), 32'h1);
        end
        cpu_wr = 1'b0; cpu_a = 32'h0;
        check("ovf_count", 32'(dut.count_q), 32'd16);
        check("ovf_flag", 32'(tx_overflow), 32'h1);
        check("ovf_head", 32'(tx_data), 32'h01);
        tx_ready = 1'b1;
        repeat (15) tick;
        check("ovf_last", 32'(tx_data), 32'h10);
        check("ovf_last_v", 32'(tx_valid), 32'h1);
        tick;
        check("ovf_empty", 32'(tx_valid), 32'h0);

        // Stop write gated by rdy_in
        tx_ready = 1'b0; rdy_in = 1'b0; cpu_wr = 1'b1; cpu_a = 32'h30004; cpu_dout = 8'h00;
        tick;
        check("stop_gated", 32'(program_stop), 32'h0);
        check("stop_gated_cnt", 32'(dut.count_q), 32'h0);
        rdy_in = 1'b1; tick;
        check("stop_set", 32'(program_stop), 32'h1);
        check("stop_cnt", 32'(dut.count_q), 32'h1);
        check("stop_byte", 32'(tx_data), 32'h00);

        // Simultaneous push and pop at count 1
        cpu_a = 32'h30000; cpu_dout = 8'h55; tx_ready = 1'b1; tick;
        check("pp_count", 32'(dut.count_q), 32'h1);
        check("pp_head", 32'(tx_data), 32'h55);
        cpu_wr = 1'b0; cpu_a = 32'h0; tx_ready = 1'b0;
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
